// File: rtl/shift_ctrl.sv
// Serial shift controller: loads a parallel word, shifts it out MSB first while
// capturing si into the LSB, and reports the received word after WIDTH steps.
module shift_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic             abort,
  input  logic             si,
  output logic             so,
  output logic             shift_en,
  output logic             busy,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid
);

  localparam int BCW = $clog2(WIDTH);
  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DCW-1:0]   div_cnt_q, div_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      rx_data_q <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      rx_data_q <= rx_data_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    rx_data_d = rx_data_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    tx_ready  = 1'b0;
    so        = 1'b0;
    shift_en  = 1'b0;
    rx_valid  = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          shreg_d   = tx_data;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        so       = shreg_q[WIDTH-1];
        shift_en = (div_cnt_q == DCW'(DIV - 1));
        // abort beats a coincident shift step: nothing moves, no DONE
        if (abort) begin
          state_d = IDLE;
        end else begin
          div_cnt_d = shift_en ? '0 : div_cnt_q + DCW'(1);
          if (shift_en) begin
            shreg_d = {shreg_q[WIDTH-2:0], si};
            if (bit_cnt_q == BCW'(WIDTH - 1)) begin
              bit_cnt_d = '0;
              rx_data_d = {shreg_q[WIDTH-2:0], si};
              state_d   = DONE;
            end else begin
              bit_cnt_d = bit_cnt_q + BCW'(1);
            end
          end
        end
      end
      DONE: begin
        rx_valid = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_data = rx_data_q;

endmodule

// File: tb/tb_shift_ctrl.sv
// Bench for shift_ctrl: DIV=1 and DIV=3 instances share stimulus and are
// compared every cycle against a transfer-phase model, plus directed scenarios.
module tb_shift_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] tx_data = '0;
  logic tx_valid = 1'b0, abort = 1'b0, si_drv = 1'b0, loop = 1'b0;

  logic d1_tx_ready, d1_so, d1_shift_en, d1_busy, d1_rx_valid, d1_si;
  logic d3_tx_ready, d3_so, d3_shift_en, d3_busy, d3_rx_valid, d3_si;
  logic [W-1:0] d1_rx_data, d3_rx_data;

  assign d1_si = loop ? d1_so : si_drv;
  assign d3_si = loop ? d3_so : si_drv;

  shift_ctrl #(.WIDTH(W), .DIV(1)) u_d1 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(d1_tx_ready),
    .abort(abort), .si(d1_si), .so(d1_so), .shift_en(d1_shift_en), .busy(d1_busy),
    .rx_data(d1_rx_data), .rx_valid(d1_rx_valid));

  shift_ctrl #(.WIDTH(W), .DIV(3)) u_d3 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(d3_tx_ready),
    .abort(abort), .si(d3_si), .so(d3_so), .shift_en(d3_shift_en), .busy(d3_busy),
    .rx_data(d3_rx_data), .rx_valid(d3_rx_valid));

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model: mk = cycles since accept (0 = idle). A transfer spans W*D shift
  // cycles then one DONE cycle; shift steps land where mk is a multiple of D.
  int           mk[2]    = '{0, 0};
  logic [W-1:0] mword[2] = '{default: '0};
  logic [W-1:0] macc[2]  = '{default: '0};
  logic [W-1:0] mrx[2]   = '{default: '0};

  function automatic int dv(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic m_so(int i);
    int k = mk[i];
    int d = dv(i);
    if (k >= 1 && k <= W*d) return mword[i][W-1-(k-1)/d];
    return 1'b0;
  endfunction

  function automatic logic [12:0] m_out(int i);
    int k = mk[i];
    int d = dv(i);
    logic se;
    se = (k >= 1) && (k <= W*d) && (k % d == 0);
    return {k == 0, m_so(i), se, k != 0, k == W*d+1, mrx[i]};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mk[i]  <= 0;
        mrx[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (mk[i] == 0) begin
          if (tx_valid) begin
            mk[i]    <= 1;
            mword[i] <= tx_data;
            macc[i]  <= '0;
          end
        end else if (mk[i] == W*dv(i)+1) begin
          mk[i] <= 0;
        end else if (abort) begin
          mk[i] <= 0;
        end else begin
          mk[i] <= mk[i] + 1;
          if (mk[i] % dv(i) == 0) begin
            macc[i] <= {macc[i][W-2:0], loop ? m_so(i) : si_drv};
            if (mk[i] == W*dv(i)) mrx[i] <= {macc[i][W-2:0], loop ? m_so(i) : si_drv};
          end
        end
      end
    end
  end

  task automatic do_cmp();
    chk("d1_out", 32'({d1_tx_ready, d1_so, d1_shift_en, d1_busy, d1_rx_valid, d1_rx_data}), 32'(m_out(0)));
    chk("d3_out", 32'({d3_tx_ready, d3_so, d3_shift_en, d3_busy, d3_rx_valid, d3_rx_data}), 32'(m_out(1)));
  endtask

  task automatic tick();
    @(negedge clk);
    do_cmp();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(d1_tx_ready && d3_tx_ready) && n < 200) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(n < 200), 32'd1);
  endtask

  task automatic run_xfer(input logic [W-1:0] d, input logic lp);
    loop = lp; tx_data = d; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    int lat, nse, nbusy, bad, r1, r2, rdy;
    logic [W-1:0] sobits, dat1, dat2;

    #1 rst = 1'b1;
    tick();
    chk("rst_d1", 32'({d1_tx_ready, d1_so, d1_shift_en, d1_busy, d1_rx_valid, d1_rx_data}), 32'h1000);
    chk("rst_d3", 32'({d3_tx_ready, d3_so, d3_shift_en, d3_busy, d3_rx_valid, d3_rx_data}), 32'h1000);
    rst = 1'b0;

    // loopback 0xA5, DIV=1
    loop = 1'b1; tx_data = 8'hA5; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    lat = 0; nse = 0; sobits = '0;
    for (int n = 1; n <= 40; n++) begin
      if (d1_shift_en) begin sobits = {sobits[W-2:0], d1_so}; nse++; end
      if (d1_rx_valid && lat == 0) lat = n;
      tick();
    end
    chk("a5_lat", 32'(lat), 32'd9);
    chk("a5_nse", 32'(nse), 32'd8);
    chk("a5_so", 32'(sobits), 32'hA5);
    chk("a5_rx", 32'(d1_rx_data), 32'hA5);
    wait_idle();

    // constant si=1, DIV=3
    loop = 1'b0; si_drv = 1'b1; tx_data = 8'h00; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    lat = 0; nse = 0; nbusy = 0; bad = 0;
    for (int n = 1; n <= 30; n++) begin
      if (d3_busy) nbusy++;
      if (d3_shift_en) begin nse++; if (n % 3 != 0) bad++; end
      if (d3_rx_valid && lat == 0) lat = n;
      tick();
    end
    chk("c3_lat", 32'(lat), 32'd25);
    chk("c3_nse", 32'(nse), 32'd8);
    chk("c3_sepos", 32'(bad), 32'd0);
    chk("c3_busy", 32'(nbusy), 32'd25);
    chk("c3_rx", 32'(d3_rx_data), 32'hFF);
    wait_idle();

    // back-to-back with tx_valid held
    loop = 1'b1; tx_data = 8'h3C; tx_valid = 1'b1;
    tick();
    tx_data = 8'hC3;
    r1 = 0; r2 = 0; rdy = 0; dat1 = '0; dat2 = '0;
    for (int n = 1; n <= 40; n++) begin
      if (d1_rx_valid) begin
        if (r1 == 0) begin r1 = n; dat1 = d1_rx_data; end
        else if (r2 == 0) begin r2 = n; dat2 = d1_rx_data; tx_valid = 1'b0; end
      end
      if (r1 != 0 && r2 == 0 && d1_tx_ready) rdy++;
      tick();
    end
    tx_valid = 1'b0;
    chk("b2b_gap", 32'(r2 - r1), 32'd10);
    chk("b2b_dat1", 32'(dat1), 32'h3C);
    chk("b2b_dat2", 32'(dat2), 32'hC3);
    chk("b2b_rdy", 32'(rdy), 32'd1);
    wait_idle();

    // abort after 4 shifts
    run_xfer(8'h3C, 1'b1);
    loop = 1'b0; si_drv = 1'b0; tx_data = 8'h55; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_busy", 32'(d1_busy), 32'd0);
    chk("ab_rxv", 32'(d1_rx_valid), 32'd0);
    chk("ab_rx", 32'(d1_rx_data), 32'h3C);
    wait_idle();
    run_xfer(8'h96, 1'b1);
    chk("ab_next_rx", 32'(d1_rx_data), 32'h96);

    // abort coinciding with the 8th shift
    loop = 1'b1; tx_data = 8'hF0; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (7) tick();
    chk("co_se8", 32'(d1_shift_en), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("co_busy", 32'(d1_busy), 32'd0);
    bad = 0;
    for (int n = 0; n < 4; n++) begin
      if (d1_rx_valid) bad++;
      tick();
    end
    chk("co_norxv", 32'(bad), 32'd0);
    chk("co_rx", 32'(d1_rx_data), 32'h96);

    // asynchronous reset mid-SHIFT
    loop = 1'b1; tx_data = 8'hA5; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (3) tick();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("ar_d1", 32'({d1_tx_ready, d1_so, d1_shift_en, d1_busy, d1_rx_valid, d1_rx_data}), 32'h1000);
    chk("ar_d3", 32'({d3_tx_ready, d3_so, d3_shift_en, d3_busy, d3_rx_valid, d3_rx_data}), 32'h1000);
    tick();
    rst = 1'b0; tx_data = 8'h5A; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    chk("ar_accept", 32'(d1_busy), 32'd1);
    wait_idle();
    chk("ar_rx", 32'(d1_rx_data), 32'h5A);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      tx_valid = 1'($urandom_range(0, 1));
      tx_data  = W'($urandom);
      si_drv   = 1'($urandom);
      abort    = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 99) == 0) loop = ~loop;
      rst      = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; tx_valid = 1'b0; abort = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
